cell_draw_scheduler: RTL
========================

# cell_draw_scheduler

Shares the VGA adapter pixel-write port between two board-cell draw requesters: the player-1 and player-2 attack paths of the turn-based gameplay controller. Accepted requests are queued in a 4-entry FIFO. Each request is then expanded into a square pixel fill and emitted as one pixel per cycle on the adapter's x/y/colour/plot inputs. The block sits between the gameplay/display control logic and `vga_adapter` at 160x120 resolution.

## Interface
Parameters:
- CELL_PX, 5: cell edge in pixels.
- B1_X0, 10: left pixel column of player-1 board.
- B2_X0, 90: left pixel column of player-2 board.
- B_Y0, 30: top pixel row of both boards.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous, active-low reset.
- req1 / req2  in  1  draw request, requester 1 / 2; held until ack.
- cell1 / cell2  in  11  {colour[2:0], cellX[3:0], cellY[3:0]}; requester number selects the board.
- ack1 / ack2  out  1  one-cycle pulse; the request is consumed this cycle.
- flush  in  1  synchronous abort: clears FIFO and stops the fill in progress.
- x  out  8  pixel column.
- y  out  7  pixel row.
- colour  out  3  pixel colour.
- plot  out  1  active-high pixel write strobe.
- busy  out  1  FIFO non-empty or fill in progress.
- bad_cell  out  1  one-cycle pulse; the consumed request had cellX>9 or cellY>9.

## Operation
- FIFO entry: {board, colour, cellX, cellY}, 12 bits, 4 deep. Count ranges 0..4.
- Arbiter:
  - At most one ack per cycle.
  - Round-robin with a last-served pointer, reset to 2 so that requester 1 wins the first tie.
  - The sole requester wins when only one is asserting.
  - When FIFO count is 4, no ack is issued unless a pop occurs in the same cycle. Push and pop in the same cycle are allowed and leave count unchanged.
- Invalid coordinates (cellX>9 or cellY>9):
  - The request is acked and bad_cell pulses in the same cycle.
  - Nothing is enqueued.
  - The arbiter pointer still advances.
- FSM states: IDLE, DRAW.
  - IDLE with count>0: pop the head, latch base pixel coordinates and colour, clear px/py, go to DRAW.
  - DRAW, each cycle: plot=1 and (x,y) = (X0 + cellX·CELL_PX + px, B_Y0 + cellY·CELL_PX + py).
  - X0 is B1_X0 for board 1 and B2_X0 for board 2.
  - Scan order is row-major: px increments first and wraps at CELL_PX-1, then py increments.
  - After the pixel (CELL_PX-1, CELL_PX-1), return to IDLE.
- Arithmetic: base coordinates are computed at pop time into 8-bit/7-bit registers. Parameters guarantee no overflow (max x 139, max y 79).
- flush:
  - Next edge: FIFO count becomes 0 and the FSM goes to IDLE.
  - No ack is issued in a flush cycle.
  - plot is 0 from the cycle after flush is sampled.
- busy = (count≠0) | (state==DRAW).

## Timing
- Reset values:
  - state IDLE, count 0, pointer 2.
  - x=0, y=0, colour=0, plot=0, ack1=ack2=0, bad_cell=0, busy=0.
- ack is combinational from req, count and pointer in the cycle the request is consumed. The requester samples ack at the edge and may present a new request in the next cycle.
- Latency: request acked in cycle t → enqueued at edge t → popped in IDLE during t+1 → first plot in t+2.
- One fill takes CELL_PX² plot cycles (25 by default). Each fill is followed by one IDLE bubble, so back-to-back cells cost 26 cycles each.
- x, y, colour and plot are registered outputs, valid together in the same cycle.
- Reset asserted mid-fill: all outputs go to reset values immediately (asynchronously). Queued entries are lost.

## Test plan
- Single request: req1 with cell1={3'b100,4'd2,4'd3}.
  - ack1 pulses once.
  - 25 consecutive plots follow, the first at cycle+2.
  - x spans 20..24, y spans 45..49, colour=4.
  - busy then drops.
- Simultaneous req1 and req2 from reset, each valid, held until acked, 3 requests each.
  - Acks alternate 1,2,1,2,1,2 whenever the FIFO has room.
  - Board-2 fills use x offset 90.
- Backpressure: 6 requests on req1 while the first fill runs.
  - 5 acks arrive before the first fill ends.
  - The 6th ack waits until the next pop.
  - No entry is lost or duplicated (order checked).
- Invalid cell: cell2 with cellX=10.
  - ack2 and bad_cell pulse in the same cycle.
  - No plot follows.
  - busy stays 0.
- flush during the 10th pixel of a fill with 2 entries queued.
  - plot is 0 from the next cycle.
  - busy is 0 one cycle after flush.
  - A subsequent request fills normally.
- resetn pulsed low mid-fill.
  - plot, ack and busy go to 0 asynchronously.
  - After release, a new req1 is acked with 2-cycle latency to the first plot.

Source files
------------

// File: rtl/cell_draw_scheduler_if.sv
// Pixel-write port shared by the two cell-draw requesters and the VGA adapter side.
interface cell_draw_scheduler_if;
  logic        req1, req2;
  logic [10:0] cell1, cell2;
  logic        ack1, ack2;
  logic        flush;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        bad_cell;

  modport master (
    output req1, req2, cell1, cell2, flush,
    input  ack1, ack2, x, y, colour, plot, busy, bad_cell
  );
  modport slave (
    input  req1, req2, cell1, cell2, flush,
    output ack1, ack2, x, y, colour, plot, busy, bad_cell
  );
endinterface

// File: rtl/cell_draw_scheduler.sv
// Arbitrates two cell-draw requesters into a 4-deep FIFO and expands each cell
// into a CELL_PX x CELL_PX row-major pixel fill, one pixel per cycle.
module cell_draw_scheduler #(
  parameter int CELL_PX = 5,
  parameter int B1_X0   = 10,
  parameter int B2_X0   = 90,
  parameter int B_Y0    = 30
) (
  input  logic                  clock,
  input  logic                  resetn,
  cell_draw_scheduler_if.slave  bus
);
  localparam int PW = $clog2(CELL_PX);

  typedef struct packed {
    logic       board;
    logic [2:0] colour;
    logic [3:0] cx;
    logic [3:0] cy;
  } entry_t;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t          state_q, state_d;
  entry_t          fifo_q [4];
  entry_t          head, new_e;
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      count_q;
  logic            ptr_q;
  logic            room, gnt1, gnt2, ok, bad, push, pop, last;
  logic [10:0]     sel;
  logic [PW-1:0]   px_q, px_d, py_q, py_d;
  logic [7:0]      bx_q, bx_d, x_q, x_d;
  logic [6:0]      by_q, by_d, y_q, y_d;
  logic [2:0]      col_q, col_d;
  logic            plot_q, plot_d;

  // ptr_q: 0 = requester 1 served last, 1 = requester 2 served last.
  assign room  = (count_q != 3'd4) | pop;
  assign gnt1  = bus.req1 & (~bus.req2 | ptr_q);
  assign gnt2  = bus.req2 & (~bus.req1 | ~ptr_q);
  assign ok    = resetn & ~bus.flush & room;
  assign bus.ack1 = gnt1 & ok;
  assign bus.ack2 = gnt2 & ok;
  assign sel   = bus.ack2 ? bus.cell2 : bus.cell1;
  assign bad   = (sel[7:4] > 4'd9) | (sel[3:0] > 4'd9);
  assign bus.bad_cell = (bus.ack1 | bus.ack2) & bad;
  assign push  = (bus.ack1 | bus.ack2) & ~bad;
  assign new_e = '{board: bus.ack2, colour: sel[10:8], cx: sel[7:4], cy: sel[3:0]};
  assign head  = fifo_q[rd_q];
  assign last  = (px_q == PW'(CELL_PX-1)) && (py_q == PW'(CELL_PX-1));

  always_ff @(posedge clock)
    if (push) fifo_q[wr_q] <= new_e;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0; rd_q <= '0; count_q <= '0; ptr_q <= 1'b1;
    end else begin
      if (bus.flush) begin
        wr_q <= '0; rd_q <= '0; count_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 2'd1;
        if (pop)  rd_q <= rd_q + 2'd1;
        count_q <= count_q + {2'b0, push} - {2'b0, pop};
      end
      if (bus.ack1)      ptr_q <= 1'b0;
      else if (bus.ack2) ptr_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != 3'd0 && !bus.flush) state_d = DRAW;
      DRAW: if (bus.flush || last)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded with the first pixel at pop time so the
  // first plot appears in the first DRAW cycle.
  always_comb begin
    pop = 1'b0; plot_d = 1'b0;
    px_d = px_q; py_d = py_q; bx_d = bx_q; by_d = by_q;
    x_d = x_q; y_d = y_q; col_d = col_q;
    case (state_q)
      IDLE: if (count_q != 3'd0 && !bus.flush) begin
        pop   = 1'b1;
        bx_d  = (head.board ? 8'(B2_X0) : 8'(B1_X0)) + 8'(head.cx) * 8'(CELL_PX);
        by_d  = 7'(B_Y0) + 7'(head.cy) * 7'(CELL_PX);
        col_d = head.colour;
        px_d  = '0; py_d = '0;
        x_d   = bx_d; y_d = by_d;
        plot_d = 1'b1;
      end
      DRAW: if (!bus.flush && !last) begin
        plot_d = 1'b1;
        if (px_q == PW'(CELL_PX-1)) begin
          px_d = '0; py_d = py_q + 1'b1;
        end else begin
          px_d = px_q + 1'b1;
        end
        x_d = bx_q + 8'(px_d);
        y_d = by_q + 7'(py_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px_q <= '0; py_q <= '0; bx_q <= '0; by_q <= '0;
      x_q <= '0; y_q <= '0; col_q <= '0; plot_q <= 1'b0;
    end else begin
      px_q <= px_d; py_q <= py_d; bx_q <= bx_d; by_q <= by_d;
      x_q <= x_d; y_q <= y_d; col_q <= col_d; plot_q <= plot_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = col_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = (count_q != 3'd0) | (state_q == DRAW);
endmodule
